// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: flag registers, skip/squash FSM and a small writeback FIFO.
// Optional build macro SKIP_COUNT_EN enables the saturating squash counter on skip_count.
module alu_writeback_stage #(
  parameter int FIFO_DEPTH = 2,
  parameter int REG_AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic [15:0]       alu_result,
  input  logic [2:0]        alu_cmp,
  input  logic              alu_zero,
  input  logic              alu_skip,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [15:0]       wb_data,
  output logic [REG_AW-1:0] wb_addr,
  output logic [2:0]        flags_q,
  output logic              zero_q,
  output logic              skip_pc,
  output logic [15:0]       skip_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = REG_AW + 16;

  typedef enum logic {IDLE, ARMED} state_t;

  state_t            state, state_nxt;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, rd_ptr_inc;
  logic [CW-1:0]     count;
  logic              accept, push, pop, set_flags, set_zero, arm, squash;
  logic              head_load;
  logic [EW-1:0]     push_word, head_nxt;

  assign in_ready   = (count < CW'(FIFO_DEPTH));
  assign wb_valid   = (count != '0);
  assign accept     = in_valid & in_ready;
  assign pop        = wb_valid & wb_ready;
  assign push_word  = {dest_reg, alu_result};
  assign rd_ptr_inc = rd_ptr + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Decode: a squash in ARMED overrides every op class.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    set_flags = 1'b0;
    set_zero  = 1'b0;
    arm       = 1'b0;
    squash    = 1'b0;
    if (accept) begin
      if (state == ARMED) begin
        squash    = 1'b1;
        state_nxt = IDLE;
      end else begin
        case (op)
          4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
            push     = 1'b1;
            set_zero = 1'b1;
          end
          4'd11: set_flags = 1'b1;
          4'd3, 4'd4, 4'd12, 4'd13: begin
            if (alu_skip) begin
              arm       = 1'b1;
              state_nxt = ARMED;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output head register tracks the entry that will be at the FIFO head next cycle.
  always_comb begin
    head_load = 1'b0;
    head_nxt  = push_word;
    if (pop) begin
      if (count >= CW'(2)) begin
        head_load = 1'b1;
        head_nxt  = mem[rd_ptr_inc];
      end else if (push) begin
        head_load = 1'b1;
      end
    end else if (count == '0 && push) begin
      head_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wb_data <= '0;
      wb_addr <= '0;
      flags_q <= '0;
      zero_q  <= 1'b0;
      skip_pc <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      count <= count + CW'(push) - CW'(pop);
      if (head_load) {wb_addr, wb_data} <= head_nxt;
      if (set_flags) flags_q <= alu_cmp;
      if (set_zero)  zero_q  <= alu_zero;
      skip_pc <= arm;
    end
  end

`ifdef SKIP_COUNT_EN
  logic [15:0] squash_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             squash_cnt <= '0;
    else if (squash && squash_cnt != '1)    squash_cnt <= squash_cnt + 16'd1;
  end

  assign skip_count = squash_cnt;
`else
  logic unused_squash;
  assign unused_squash = squash;
  assign skip_count    = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage (default FIFO_DEPTH=2, REG_AW=4).
module tb_alu_writeback_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [3:0]  dest_reg;
  logic [15:0] alu_result;
  logic [2:0]  alu_cmp;
  logic        alu_zero;
  logic        alu_skip;
  logic        wb_valid;
  logic        wb_ready;
  logic [15:0] wb_data;
  logic [3:0]  wb_addr;
  logic [2:0]  flags_q;
  logic        zero_q;
  logic        skip_pc;
  logic [15:0] skip_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_skip = 16'h0;

  alu_writeback_stage #(.FIFO_DEPTH(2), .REG_AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dest_reg(dest_reg), .alu_result(alu_result), .alu_cmp(alu_cmp),
    .alu_zero(alu_zero), .alu_skip(alu_skip), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_data(wb_data), .wb_addr(wb_addr),
    .flags_q(flags_q), .zero_q(zero_q), .skip_pc(skip_pc), .skip_count(skip_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] o, input logic [3:0] d, input logic [15:0] r,
                        input logic [2:0] c, input logic z, input logic s);
    in_valid = 1'b1; op = o; dest_reg = d; alu_result = r;
    alu_cmp = c; alu_zero = z; alu_skip = s;
  endtask

  task automatic send(input logic [3:0] o, input logic [3:0] d, input logic [15:0] r,
                      input logic [2:0] c, input logic z, input logic s);
    set_in(o, d, r, c, z, s);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    checks++; if (wb_data !== 16'h0) begin errors++; $display("FAIL reset_wb_data got %h exp 0000", wb_data); end
    checks++; if (wb_addr !== 4'h0) begin errors++; $display("FAIL reset_wb_addr got %h exp 0", wb_addr); end
    checks++; if (flags_q !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", flags_q); end
    checks++; if (zero_q !== 1'b0) begin errors++; $display("FAIL reset_zero got %b exp 0", zero_q); end
    checks++; if (skip_pc !== 1'b0) begin errors++; $display("FAIL reset_skip_pc got %b exp 0", skip_pc); end
    checks++; if (skip_count !== 16'h0) begin errors++; $display("FAIL reset_skip_count got %h exp 0000", skip_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_push();
    wb_ready = 1'b1;
    send(4'd0, 4'd3, 16'h1234, 3'b000, 1'b0, 1'b0);
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL push_wb_valid got %b exp 1", wb_valid); end
    checks++; if (wb_addr !== 4'd3) begin errors++; $display("FAIL push_wb_addr got %h exp 3", wb_addr); end
    checks++; if (wb_data !== 16'h1234) begin errors++; $display("FAIL push_wb_data got %h exp 1234", wb_data); end
    checks++; if (zero_q !== 1'b0) begin errors++; $display("FAIL push_zero got %b exp 0", zero_q); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL push_drained got %b exp 0", wb_valid); end
    checks++; if (wb_data !== 16'h1234) begin errors++; $display("FAIL empty_hold_data got %h exp 1234", wb_data); end
    send(4'd5, 4'd9, 16'h0000, 3'b000, 1'b1, 1'b0);
    checks++; if (zero_q !== 1'b1) begin errors++; $display("FAIL op5_zero got %b exp 1", zero_q); end
    checks++; if (wb_addr !== 4'd9) begin errors++; $display("FAIL op5_addr got %h exp 9", wb_addr); end
    tick();
  endtask

  task automatic test_full();
    wb_ready = 1'b0;
    send(4'd0, 4'd1, 16'h1111, 3'b000, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after1 got %b exp 1", in_ready); end
    send(4'd0, 4'd2, 16'h2222, 3'b000, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_after2 got %b exp 0", in_ready); end
    checks++; if (wb_data !== 16'h1111) begin errors++; $display("FAIL full_head got %h exp 1111", wb_data); end
    set_in(4'd0, 4'd3, 16'h3333, 3'b000, 1'b0, 1'b0);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_held_ready got %b exp 0", in_ready); end
    checks++; if (wb_data !== 16'h1111 || wb_addr !== 4'd1) begin errors++; $display("FAIL full_head_stable got %h/%h exp 1111/1", wb_data, wb_addr); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b exp 1", in_ready); end
    checks++; if (wb_data !== 16'h2222 || wb_valid !== 1'b1) begin errors++; $display("FAIL full_second got %h v%b exp 2222 v1", wb_data, wb_valid); end
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_third_taken got %b exp 0", in_ready); end
    wb_ready = 1'b1;
    tick();
    checks++; if (wb_data !== 16'h3333 || wb_addr !== 4'd3) begin errors++; $display("FAIL full_third got %h/%h exp 3333/3", wb_data, wb_addr); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %b exp 0", wb_valid); end
  endtask

  task automatic test_compare();
    wb_ready = 1'b1;
    send(4'd11, 4'd4, 16'hAAAA, 3'b010, 1'b1, 1'b0);
    checks++; if (flags_q !== 3'b010) begin errors++; $display("FAIL cmp_flags got %b exp 010", flags_q); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL cmp_no_push got %b exp 0", wb_valid); end
    send(4'd0, 4'd4, 16'h0044, 3'b101, 1'b0, 1'b0);
    checks++; if (flags_q !== 3'b010) begin errors++; $display("FAIL cmp_flags_kept got %b exp 010", flags_q); end
    tick();
    send(4'd14, 4'd8, 16'h0000, 3'b111, 1'b1, 1'b1);
    checks++; if (wb_valid !== 1'b0 || zero_q !== 1'b0 || flags_q !== 3'b010 || skip_pc !== 1'b0)
      begin errors++; $display("FAIL op14_discard got v%b z%b f%b s%b exp v0 z0 f010 s0", wb_valid, zero_q, flags_q, skip_pc); end
  endtask

  task automatic test_skip();
    wb_ready = 1'b1;
    send(4'd12, 4'd0, 16'h0, 3'b000, 1'b0, 1'b1);
    checks++; if (skip_pc !== 1'b1) begin errors++; $display("FAIL skip_pulse got %b exp 1", skip_pc); end
    send(4'd0, 4'd5, 16'h5555, 3'b000, 1'b0, 1'b0);
`ifdef SKIP_COUNT_EN
    exp_skip = exp_skip + 16'd1;
`endif
    checks++; if (skip_pc !== 1'b0) begin errors++; $display("FAIL skip_pulse_end got %b exp 0", skip_pc); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL skip_squashed got %b exp 0", wb_valid); end
    checks++; if (skip_count !== exp_skip) begin errors++; $display("FAIL skip_count got %h exp %h", skip_count, exp_skip); end
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b1;
    send(4'd13, 4'd0, 16'h0, 3'b000, 1'b0, 1'b1);
    checks++; if (skip_pc !== 1'b1) begin errors++; $display("FAIL b2b_pulse got %b exp 1", skip_pc); end
    tick();
    checks++; if (skip_pc !== 1'b0) begin errors++; $display("FAIL b2b_idle_pulse got %b exp 0", skip_pc); end
    send(4'd4, 4'd0, 16'h0, 3'b000, 1'b0, 1'b1);
`ifdef SKIP_COUNT_EN
    exp_skip = exp_skip + 16'd1;
`endif
    checks++; if (skip_pc !== 1'b0) begin errors++; $display("FAIL b2b_no_second got %b exp 0", skip_pc); end
    checks++; if (skip_count !== exp_skip) begin errors++; $display("FAIL b2b_count got %h exp %h", skip_count, exp_skip); end
    send(4'd3, 4'd0, 16'h0, 3'b000, 1'b0, 1'b0);
    checks++; if (skip_pc !== 1'b0) begin errors++; $display("FAIL notaken_pulse got %b exp 0", skip_pc); end
    send(4'd0, 4'd6, 16'h0066, 3'b000, 1'b0, 1'b0);
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h0066 || wb_addr !== 4'd6)
      begin errors++; $display("FAIL notaken_exec got v%b %h/%h exp v1 0066/6", wb_valid, wb_data, wb_addr); end
    tick();
  endtask

  task automatic test_reset_mid();
    wb_ready = 1'b0;
    send(4'd0, 4'd1, 16'hAAA1, 3'b000, 1'b0, 1'b0);
    send(4'd0, 4'd2, 16'hAAA2, 3'b000, 1'b0, 1'b0);
    set_in(4'd12, 4'd0, 16'h0, 3'b000, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got %b exp 0", in_ready); end
    in_valid = 1'b0;
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    send(4'd12, 4'd0, 16'h0, 3'b000, 1'b0, 1'b1);
    checks++; if (skip_pc !== 1'b1) begin errors++; $display("FAIL mid_armed_pulse got %b exp 1", skip_pc); end
    rst_n = 1'b0;
    #2;
    exp_skip = 16'h0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mid_wb_valid got %b exp 0", wb_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", in_ready); end
    checks++; if (skip_pc !== 1'b0) begin errors++; $display("FAIL mid_skip_pc got %b exp 0", skip_pc); end
    tick();
    rst_n = 1'b1;
    tick();
    wb_ready = 1'b1;
    send(4'd0, 4'd7, 16'h7777, 3'b000, 1'b0, 1'b0);
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h7777 || wb_addr !== 4'd7)
      begin errors++; $display("FAIL mid_not_squashed got v%b %h/%h exp v1 7777/7", wb_valid, wb_data, wb_addr); end
    checks++; if (skip_count !== exp_skip) begin errors++; $display("FAIL mid_count got %h exp %h", skip_count, exp_skip); end
    tick();
  endtask

  initial begin
    in_valid = 1'b0; op = 4'd0; dest_reg = 4'd0; alu_result = 16'h0;
    alu_cmp = 3'b000; alu_zero = 1'b0; alu_skip = 1'b0; wb_ready = 1'b0;
    test_reset();
    test_push();
    test_full();
    test_compare();
    test_skip();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
